bsg_nasti_client_resp_arbiter: RTL

// - Shares one NASTI read-response (R) channel between els_p response sources.
// - Each source presents a 71-bit response word {last, data[63:0], id[5:0]} with a valid/yumi handshake.
// - Round-robin arbitration; grant is held for a whole burst, up to and including the beat with last=1.
// - Winning beat is formatted onto the 73-bit NASTI R word and registered in a one-entry output stage.
//

---
 rtl/bsg_nasti_client_resp_arbiter_if.sv | 11 +
 rtl/bsg_nasti_client_resp_arbiter.sv | 64 ++++++
 2 files changed

// File: rtl/bsg_nasti_client_resp_arbiter_if.sv
// bsg_nasti_client_resp_arbiter_if: response-source bundle plus the NASTI R channel
interface bsg_nasti_client_resp_arbiter_if #(parameter int els_p = 4);
  logic [els_p-1:0]    resp_valid;
  logic [els_p*71-1:0] resp_data;
  logic [els_p-1:0]    resp_yumi;
  logic                r_valid;
  logic [72:0]         r_data;
  logic                r_ready;
  modport master (input resp_valid, resp_data, r_ready, output resp_yumi, r_valid, r_data);
  modport slave (output resp_valid, resp_data, r_ready, input resp_yumi, r_valid, r_data);
endinterface

// File: rtl/bsg_nasti_client_resp_arbiter.sv
// bsg_nasti_client_resp_arbiter: burst-locked round-robin merge of response sources onto one NASTI R channel
// Optional macro BSG_NASTI_RESP_ARB_ID_TAG_EN replaces the low id bits with the granted source index.
module bsg_nasti_client_resp_arbiter #(parameter int els_p = 4) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_nasti_client_resp_arbiter_if.master bus
);
  localparam int lg_els_lp = $clog2(els_p);
  typedef enum logic {idle, locked} state_e;
  state_e state;
  logic [lg_els_lp-1:0] rr_ptr, owner, g, idx;
  logic found, load, take;
  logic [70:0] src;
  logic [5:0] id;
  assign load = ~bus.r_valid | bus.r_ready;
  assign take = load & bus.resp_valid[g] & reset_n_i;
  assign src  = bus.resp_data[71*g +: 71];
`ifdef BSG_NASTI_RESP_ARB_ID_TAG_EN
  assign id = {src[5:lg_els_lp], g};
`else
  assign id = src[5:0];
`endif
  // pick the burst owner when locked, otherwise the first valid source at or after rr_ptr
  always_comb begin
    g = rr_ptr;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      idx = lg_els_lp'((int'(rr_ptr) + i) % els_p);
      if (!found && bus.resp_valid[idx]) begin
        g = idx;
        found = 1'b1;
      end
    end
    if (state == locked) g = owner;
  end
  // dequeue only the granted source, and only when the output stage can accept
  always_comb begin
    bus.resp_yumi = '0;
    bus.resp_yumi[g] = take;
  end
  // output register plus burst lock / round-robin pointer bookkeeping
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bus.r_valid <= 1'b0;
      bus.r_data <= '0;
      state <= idle;
      rr_ptr <= '0;
      owner <= '0;
    end else begin
      if (load) bus.r_valid <= take;
      if (take) begin
        bus.r_data <= {2'b00, src[69:6], src[70], id};
        if (src[70]) begin
          state <= idle;
          rr_ptr <= (int'(g) == els_p - 1) ? '0 : g + 1'b1;
        end else begin
          state <= locked;
          owner <= g;
        end
      end
    end
  end
endmodule
